alu_control: RTL and testbench
==============================

ALU_CONTROL -- requirements
Module: alu_control

Interface
REQ-001 The block SHALL declare parameter DIV_CYCLES, default 32, meaning the number of clock cycles a DIVU operation occupies the divider.
REQ-002 The block SHALL declare parameter ILLEGAL_SEL, default 6'b111111, meaning the select code that drives the result mux to its 32'b0 default.
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset, with these ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-low reset.
- InstValid  input  1  funct code on Signal is presented this cycle.
- Signal  input  6  funct code; the block decodes AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SLL 000000, DIVU 011011, MFHI 010000, MFLO 010010.
- Ready  output  1  the block can accept an instruction this cycle.
- ALUOp  output  3  ALU operation: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
- ShiftEn  output  1  shifter enable.
- DivStart  output  1  one-cycle divider start pulse.
- HiLoWrite  output  1  one-cycle write strobe to the Hi/Lo registers.
- MuxSel  output  6  select code driven to the result mux.
- ResultValid  output  1  the result mux output is valid this cycle.
- Illegal  output  1  one-cycle flag for an undecoded funct code.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, DIV_BUSY and DIV_DONE.
REQ-005 An instruction SHALL be accepted only on a rising edge where InstValid=1 and Ready=1; InstValid while Ready=0 SHALL be ignored, with no state change and no queuing.
REQ-006 Ready SHALL be 1 in IDLE and 0 in DIV_BUSY and DIV_DONE.
REQ-007 Single-cycle ops (AND, OR, ADD, SUB, SLT, SLL, MFHI, MFLO) accepted at edge t SHALL be fully registered at edge t:
- during cycle t+1, MuxSel SHALL equal the accepted funct and ResultValid SHALL be 1 for exactly that one cycle;
- the FSM SHALL stay in IDLE, so back-to-back issue every cycle SHALL be sustained.
REQ-008 ALUOp SHALL be registered with the encoding of REQ-003 for ALU ops only, and SHALL hold its previous value for all other ops.
REQ-009 ShiftEn SHALL be 1 for exactly one cycle after SLL is accepted, and 0 otherwise.
REQ-010 Accepting DIVU SHALL cause all of the following:
- transition to DIV_BUSY;
- DivStart=1 for exactly the next cycle;
- a 6-bit cycle counter loaded to 1.
REQ-011 In DIV_BUSY the counter SHALL increment each cycle; when the counter equals DIV_CYCLES the FSM SHALL move to DIV_DONE.
REQ-012 In DIV_DONE, HiLoWrite SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-013 DIVU timing: accepted at edge t, HiLoWrite SHALL be high during cycle t+DIV_CYCLES+1 and Ready SHALL return to 1 at cycle t+DIV_CYCLES+2.
REQ-014 DIVU SHALL NOT assert ResultValid.
REQ-015 MFHI/MFLO issued while a DIVU is in progress SHALL stall through Ready=0 and be accepted only after HiLoWrite has occurred, so Hi/Lo reads never return stale data.
REQ-016 An unrecognised funct code, when accepted, SHALL produce the following in the next cycle:
- Illegal=1 for one cycle;
- MuxSel=ILLEGAL_SEL;
- ResultValid=0;
- the FSM stays in IDLE.
REQ-017 In any cycle with no accepted instruction, ResultValid, ShiftEn, DivStart, HiLoWrite and Illegal SHALL all be 0, and MuxSel SHALL hold its last value.
REQ-018 The counter SHALL NOT wrap: it saturates at DIV_CYCLES, and DIV_CYCLES is limited to the range 1..63.

Reset
REQ-019 While reset=0, the block SHALL asynchronously force the following, independent of clk:
- FSM to IDLE and counter to 0;
- Ready=1;
- ALUOp=000;
- MuxSel=ILLEGAL_SEL;
- ShiftEn, DivStart, HiLoWrite, ResultValid and Illegal all 0.
REQ-020 Reset asserted mid-DIVU SHALL abort the operation, with no HiLoWrite afterwards.
REQ-021 The first accept after reset SHALL be possible on the first rising edge following reset deassertion.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- ADD, SUB, SLT on three consecutive edges -> ResultValid high for 3 consecutive cycles with MuxSel 100000, 100010, 101010 and ALUOp 010, 110, 111.
- DIVU at edge 0, DIV_CYCLES=32 -> DivStart high in cycle 1, Ready low in cycles 1..33, HiLoWrite high in cycle 33 only, Ready high in cycle 34.
- DIVU then MFHI held on InstValid -> MFHI accepted at edge 34, MuxSel=010000 with ResultValid high in cycle 35.
- Signal=6'b000001 -> Illegal high for one cycle, MuxSel=111111, ResultValid=0.
- reset=0 pulsed during DIV_BUSY with counter=10 -> all outputs at reset values immediately, no HiLoWrite, Ready=1 after release.
- SLL -> ShiftEn and ResultValid high for one cycle, MuxSel=000000, ALUOp unchanged.

Source files
------------

// File: rtl/alu_control_if.sv
// rtl/alu_control_if.sv - instruction issue and ALU/divider control signal bundle
interface alu_control_if;
    logic       InstValid;
    logic [5:0] Signal;
    logic       Ready;
    logic [2:0] ALUOp;
    logic       ShiftEn;
    logic       DivStart;
    logic       HiLoWrite;
    logic [5:0] MuxSel;
    logic       ResultValid;
    logic       Illegal;

    modport master (
        output InstValid, Signal,
        input  Ready, ALUOp, ShiftEn, DivStart, HiLoWrite, MuxSel, ResultValid, Illegal
    );

    modport slave (
        input  InstValid, Signal,
        output Ready, ALUOp, ShiftEn, DivStart, HiLoWrite, MuxSel, ResultValid, Illegal
    );
endinterface

// File: rtl/alu_control.sv
// rtl/alu_control.sv - funct decoder driving ALU op, shifter, divider sequencing and result mux
module alu_control #(
    parameter int unsigned DIV_CYCLES  = 32,
    parameter logic [5:0]  ILLEGAL_SEL = 6'b111111
) (
    input  logic clk,
    input  logic reset,
    alu_control_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DIV_BUSY, DIV_DONE} state_t;

    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_DIVU = 6'b011011;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] DIV_LAST = 6'(DIV_CYCLES);

    state_t     state, state_nxt;
    logic [5:0] cnt, cnt_nxt;
    logic       accept;
    logic       is_single, is_alu, is_sll, is_div;
    logic [2:0] alu_code;

    logic [2:0] alu_op_q;
    logic [5:0] mux_sel_q;
    logic       shift_en_q, div_start_q, result_valid_q, illegal_q;

    always_comb begin
        is_single = 1'b0;
        is_alu    = 1'b0;
        is_sll    = 1'b0;
        is_div    = 1'b0;
        alu_code  = 3'b000;
        case (bus.Signal)
            F_AND:  begin is_single = 1'b1; is_alu = 1'b1; alu_code = 3'b000; end
            F_OR:   begin is_single = 1'b1; is_alu = 1'b1; alu_code = 3'b001; end
            F_ADD:  begin is_single = 1'b1; is_alu = 1'b1; alu_code = 3'b010; end
            F_SUB:  begin is_single = 1'b1; is_alu = 1'b1; alu_code = 3'b110; end
            F_SLT:  begin is_single = 1'b1; is_alu = 1'b1; alu_code = 3'b111; end
            F_SLL:  begin is_single = 1'b1; is_sll = 1'b1; end
            F_MFHI: is_single = 1'b1;
            F_MFLO: is_single = 1'b1;
            F_DIVU: is_div = 1'b1;
            default: ;
        endcase
    end

    // Ready is purely a function of state, so a held MFHI/MFLO waits out the divide.
    assign accept = bus.InstValid && (state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept && is_div) begin
                    state_nxt = DIV_BUSY;
                    cnt_nxt   = 6'd1;
                end
            end
            DIV_BUSY: begin
                if (cnt == DIV_LAST) state_nxt = DIV_DONE;
                else                 cnt_nxt   = cnt + 6'd1;
            end
            DIV_DONE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_op_q       <= 3'b000;
            mux_sel_q      <= ILLEGAL_SEL;
            shift_en_q     <= 1'b0;
            div_start_q    <= 1'b0;
            result_valid_q <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            shift_en_q     <= 1'b0;
            div_start_q    <= 1'b0;
            result_valid_q <= 1'b0;
            illegal_q      <= 1'b0;
            if (accept) begin
                if (is_single) begin
                    mux_sel_q      <= bus.Signal;
                    result_valid_q <= 1'b1;
                    shift_en_q     <= is_sll;
                    if (is_alu) alu_op_q <= alu_code;
                end else if (is_div) begin
                    div_start_q <= 1'b1;
                end else begin
                    mux_sel_q <= ILLEGAL_SEL;
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    assign bus.Ready       = (state == IDLE);
    assign bus.HiLoWrite   = (state == DIV_DONE);
    assign bus.ALUOp       = alu_op_q;
    assign bus.MuxSel      = mux_sel_q;
    assign bus.ShiftEn     = shift_en_q;
    assign bus.DivStart    = div_start_q;
    assign bus.ResultValid = result_valid_q;
    assign bus.Illegal     = illegal_q;
endmodule

// File: tb/tb_alu_control.sv
// tb/tb_alu_control.sv - scoreboard bench for alu_control
module tb_alu_control;
    localparam int D = 32;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_DIVU = 6'b011011;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_control_if bus ();

    alu_control #(.DIV_CYCLES(D), .ILLEGAL_SEL(6'b111111)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] mux;
        logic       rv;
        logic [2:0] alu;
        logic       sh;
        logic       ill;
    } exp_t;

    exp_t       sbq[$];
    logic [5:0] m_mux;
    logic [2:0] m_alu;
    int         errors = 0;
    int         checks = 0;

    function automatic exp_t predict(input logic [5:0] f);
        exp_t e;
        e.rv  = 1'b1;
        e.sh  = 1'b0;
        e.ill = 1'b0;
        case (f)
            F_AND:  begin m_alu = 3'b000; m_mux = f; end
            F_OR:   begin m_alu = 3'b001; m_mux = f; end
            F_ADD:  begin m_alu = 3'b010; m_mux = f; end
            F_SUB:  begin m_alu = 3'b110; m_mux = f; end
            F_SLT:  begin m_alu = 3'b111; m_mux = f; end
            F_SLL:  begin m_mux = f; e.sh = 1'b1; end
            F_MFHI: m_mux = f;
            F_MFLO: m_mux = f;
            default: begin m_mux = 6'b111111; e.rv = 1'b0; e.ill = 1'b1; end
        endcase
        e.mux = m_mux;
        e.alu = m_alu;
        return e;
    endfunction

    function automatic exp_t quiet();
        exp_t e;
        e.mux = m_mux;
        e.rv  = 1'b0;
        e.alu = m_alu;
        e.sh  = 1'b0;
        e.ill = 1'b0;
        return e;
    endfunction

    function automatic exp_t observed();
        return {bus.MuxSel, bus.ResultValid, bus.ALUOp, bus.ShiftEn, bus.Illegal};
    endfunction

    task automatic issue(input logic [5:0] f);
        bus.InstValid = 1'b1;
        bus.Signal    = f;
        sbq.push_back(predict(f));
    endtask

    task automatic go_idle();
        bus.InstValid = 1'b0;
        bus.Signal    = 6'($urandom);
        sbq.push_back(quiet());
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        #12;
        m_mux = 6'b111111;
        m_alu = 3'b000;
        e = quiet();
        checks++;
        if (observed() !== e) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", observed(), e);
        end
        checks++;
        if ({bus.Ready, bus.DivStart, bus.HiLoWrite} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 100", {bus.Ready, bus.DivStart, bus.HiLoWrite});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu_back_to_back();
        logic [5:0] ops [6];
        exp_t e;
        ops = '{F_ADD, F_SUB, F_SLT, F_AND, F_OR, F_MFLO};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i]);
            step();
            e = sbq.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL b2b_op%0d: got %h expected %h", i, observed(), e);
            end
        end
        go_idle();
        step();
        e = sbq.pop_front();
        checks++;
        if (observed() !== e || bus.Ready !== 1'b1 || bus.DivStart !== 1'b0 || bus.HiLoWrite !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got %h rdy %b expected %h rdy 1", observed(), bus.Ready, e);
        end
    endtask

    task automatic test_sll();
        exp_t e;
        issue(F_SLL);
        step();
        e = sbq.pop_front();
        checks++;
        if (observed() !== e) begin
            errors++;
            $display("FAIL sll: got %h expected %h", observed(), e);
        end
        go_idle();
        step();
        e = sbq.pop_front();
        checks++;
        if (observed() !== e) begin
            errors++;
            $display("FAIL sll_after: got %h expected %h", observed(), e);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] codes [3];
        exp_t e;
        codes = '{6'b000001, 6'b111111, 6'b011010};
        for (int i = 0; i < 3; i++) begin
            issue(codes[i]);
            step();
            e = sbq.pop_front();
            checks++;
            if (observed() !== e || bus.Ready !== 1'b1) begin
                errors++;
                $display("FAIL illegal%0d: got %h rdy %b expected %h rdy 1", i, observed(), bus.Ready, e);
            end
            go_idle();
            step();
            e = sbq.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL illegal_after%0d: got %h expected %h", i, observed(), e);
            end
        end
    endtask

    task automatic test_divu_mfhi();
        exp_t e;
        bus.InstValid = 1'b1;
        bus.Signal    = F_DIVU;
        step();
        bus.Signal = F_MFHI;
        for (int c = 1; c <= D + 1; c++) begin
            e = quiet();
            checks++;
            if (bus.DivStart !== (c == 1) || bus.Ready !== 1'b0 ||
                bus.HiLoWrite !== (c == D + 1) || observed() !== e) begin
                errors++;
                $display("FAIL div_cycle%0d: ds %b rdy %b hlw %b out %h expected ds %b rdy 0 hlw %b out %h",
                         c, bus.DivStart, bus.Ready, bus.HiLoWrite, observed(), c == 1, c == D + 1, e);
            end
            step();
        end
        checks++;
        if (bus.Ready !== 1'b1 || bus.HiLoWrite !== 1'b0 || bus.ResultValid !== 1'b0) begin
            errors++;
            $display("FAIL div_release: rdy %b hlw %b rv %b expected 1 0 0", bus.Ready, bus.HiLoWrite, bus.ResultValid);
        end
        sbq.push_back(predict(F_MFHI));
        step();
        e = sbq.pop_front();
        checks++;
        if (observed() !== e) begin
            errors++;
            $display("FAIL mfhi_after_div: got %h expected %h", observed(), e);
        end
        go_idle();
        step();
        e = sbq.pop_front();
        checks++;
        if (observed() !== e || bus.Ready !== 1'b1) begin
            errors++;
            $display("FAIL mfhi_idle: got %h rdy %b expected %h rdy 1", observed(), bus.Ready, e);
        end
    endtask

    task automatic test_reset_mid_div();
        exp_t e;
        bus.InstValid = 1'b1;
        bus.Signal    = F_DIVU;
        step();
        bus.InstValid = 1'b0;
        for (int c = 1; c < 10; c++) step();
        #2;
        rst_n = 1'b0;
        #1;
        m_mux = 6'b111111;
        m_alu = 3'b000;
        e = quiet();
        checks++;
        if (observed() !== e || bus.Ready !== 1'b1 || bus.HiLoWrite !== 1'b0 || bus.DivStart !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %h rdy %b hlw %b ds %b expected %h rdy 1 hlw 0 ds 0",
                     observed(), bus.Ready, bus.HiLoWrite, bus.DivStart, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < D + 8; c++) begin
            step();
            checks++;
            if (bus.HiLoWrite !== 1'b0 || bus.Ready !== 1'b1) begin
                errors++;
                $display("FAIL post_reset%0d: hlw %b rdy %b expected 0 1", c, bus.HiLoWrite, bus.Ready);
            end
        end
        issue(F_OR);
        step();
        e = sbq.pop_front();
        checks++;
        if (observed() !== e) begin
            errors++;
            $display("FAIL accept_after_abort: got %h expected %h", observed(), e);
        end
        go_idle();
        step();
        void'(sbq.pop_front());
    endtask

    initial begin
        bus.InstValid = 1'b0;
        bus.Signal    = 6'd0;
        m_mux = 6'b111111;
        m_alu = 3'b000;
        test_reset();
        test_alu_back_to_back();
        test_sll();
        test_illegal();
        test_divu_mfhi();
        test_reset_mid_div();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
